// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO.
// Frames: start, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 1250,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        din,
    input  logic                        din_valid,
    output logic                        din_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        tx_done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [15:0] LAST_BAUD = 16'(BAUD_DIV - 1);
    localparam logic [3:0]  LAST_DB   = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_SB   = 4'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);
    localparam logic        ODD       = (PARITY == 1);
    localparam logic        HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 ready_q;
    logic                 wr_en;
    logic                 pop;
    logic                 empty;

    // Transmitter state
    state_t               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 baud_end;
    logic [DATA_BITS-1:0] head;

    assign empty      = (count_q == '0);
    assign din_ready  = ready_q && (count_q != FULL);
    assign wr_en      = din_valid && din_ready;
    assign head       = mem[rd_ptr_q];
    assign baud_end   = (cnt_q == LAST_BAUD);

    assign tx         = tx_q;
    assign tx_done    = done_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != S_IDLE) || !empty;

    // Write port: store accepted characters at the write pointer
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Ready is held low in reset and comes up on the first edge after it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Pointers wrap naturally; count tracks pushes minus pops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case ({wr_en, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Next-state logic: bit timing, shifting and the registered tx level
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        pop     = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = baud_end ? 16'd0 : cnt_q + 16'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                tx_d  = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = head;
                    par_d   = (^head) ^ ODD;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    bit_d   = 4'd0;
                    tx_d    = sh_q[0];
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_q == LAST_DB) begin
                        bit_d = 4'd0;
                        if (HAS_PAR) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        sh_d  = sh_q >> 1;
                        tx_d  = sh_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    bit_d   = 4'd0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    if (bit_q == LAST_SB) begin
                        done_d = 1'b1;
                        bit_d  = 4'd0;
                        if (!empty) begin
                            pop     = 1'b1;
                            sh_d    = head;
                            par_d   = (^head) ^ ODD;
                            state_d = S_START;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
                bit_d   = 4'd0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Transmitter registers; reset aborts any frame with the line high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 4'd0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

endmodule
